// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, framing bytes, FSM state encodings and helpers for the uart command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] RESP_DEFAULT = 8'h5A;

    // CMD..CSUM are contiguous so the timeout window is a simple range check
    localparam logic [3:0] ST_HUNT   = 4'd0;
    localparam logic [3:0] ST_CMD    = 4'd1;
    localparam logic [3:0] ST_ADDR   = 4'd2;
    localparam logic [3:0] ST_DHI    = 4'd3;
    localparam logic [3:0] ST_DLO    = 4'd4;
    localparam logic [3:0] ST_CSUM   = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_RDWAIT = 4'd7;
    localparam logic [3:0] ST_RESP   = 4'd8;

    function automatic logic [7:0] err_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_txq.sv
// 3-entry response byte queue: bulk load of 1..3 bytes, one byte per tx_pop answered with tx_ack.
module uart_cmd_txq
    import uart_cmd_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [1:0]      load_cnt,
    input  logic [2:0][7:0] load_bytes,
    input  logic            tx_pop,
    output logic [7:0]      tx_data,
    output logic            tx_ack,
    output logic            empty
);

    logic [2:0][7:0] mem;
    logic [1:0]      cnt;

    assign empty = (cnt == 2'd0);

    // Entry 0 is the head; a pop shifts the remaining bytes down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            cnt     <= 2'd0;
            tx_data <= 8'h00;
            tx_ack  <= 1'b0;
        end else begin
            tx_ack <= 1'b0;
            if (load) begin
                mem <= load_bytes;
                cnt <= load_cnt;
            end else if (tx_pop && !tx_ack && cnt != 2'd0) begin
                tx_ack  <= 1'b1;
                tx_data <= mem[0];
                mem     <= {8'h00, mem[2], mem[1]};
                cnt     <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Framed register read/write packet parser between the uart and a register bus.
// Define UART_CMD_WRITE_ACK_EN to answer each successful write with a single RESP_BYTE.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic [7:0]  RESP_BYTE      = RESP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ack,
    input  logic        tx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_ack,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]      state, state_d;
    logic            is_wr, is_wr_d;
    logic [7:0]      addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d, csum_q, csum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      err_d, reg_addr_d;
    logic [15:0]     reg_wdata_d;
    logic            we_d, re_d, in_pkt;
    logic            q_load, q_empty;
    logic [1:0]      q_cnt;
    logic [2:0][7:0] q_bytes;

    assign in_pkt = (state >= ST_CMD) && (state <= ST_CSUM);

    always_comb begin
        state_d     = state;
        is_wr_d     = is_wr;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        csum_d      = csum_q;
        err_d       = err_cnt;
        reg_addr_d  = reg_addr;
        reg_wdata_d = reg_wdata;
        we_d        = 1'b0;
        re_d        = 1'b0;
        q_load      = 1'b0;
        q_cnt       = 2'd0;
        q_bytes     = {reg_rdata[7:0], reg_rdata[15:8], RESP_BYTE};
        tmo_d       = (in_pkt && !rx_ack) ? tmo_q + TW'(1) : '0;

        case (state)
            ST_HUNT: if (rx_ack && rx_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD: if (rx_ack) begin
                if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                    is_wr_d = (rx_data == CMD_WRITE);
                    csum_d  = rx_data;
                    state_d = ST_ADDR;
                end else begin
                    err_d   = err_inc(err_cnt);
                    state_d = ST_HUNT;
                end
            end
            ST_ADDR: if (rx_ack) begin
                addr_d  = rx_data;
                csum_d  = csum_q ^ rx_data;
                state_d = is_wr ? ST_DHI : ST_CSUM;
            end
            ST_DHI: if (rx_ack) begin
                dhi_d   = rx_data;
                csum_d  = csum_q ^ rx_data;
                state_d = ST_DLO;
            end
            ST_DLO: if (rx_ack) begin
                dlo_d   = rx_data;
                csum_d  = csum_q ^ rx_data;
                state_d = ST_CSUM;
            end
            ST_CSUM: if (rx_ack) begin
                if (rx_data == csum_q) begin
                    // Bus outputs only move here, so they hold between strobes
                    reg_addr_d = addr_q;
                    if (is_wr) reg_wdata_d = {dhi_q, dlo_q};
                    we_d    = is_wr;
                    re_d    = !is_wr;
                    state_d = ST_EXEC;
                end else begin
                    err_d   = err_inc(err_cnt);
                    state_d = ST_HUNT;
                end
            end
            ST_EXEC: begin
                if (rx_ack) err_d = err_inc(err_cnt);
                if (is_wr) begin
`ifdef UART_CMD_WRITE_ACK_EN
                    q_load  = 1'b1;
                    q_cnt   = 2'd1;
                    state_d = ST_RESP;
`else
                    state_d = ST_HUNT;
`endif
                end else begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (rx_ack) err_d = err_inc(err_cnt);
                q_load  = 1'b1;
                q_cnt   = 2'd3;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rx_ack) err_d = err_inc(err_cnt);
                if (q_empty) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase

        // A byte arriving on the expiry cycle keeps the packet alive
        if (in_pkt && !rx_ack && tmo_q == TMO_LAST) begin
            state_d = ST_HUNT;
            err_d   = err_inc(err_cnt);
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HUNT;
            is_wr     <= 1'b0;
            addr_q    <= 8'h00;
            dhi_q     <= 8'h00;
            dlo_q     <= 8'h00;
            csum_q    <= 8'h00;
            tmo_q     <= '0;
            err_cnt   <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 16'h0000;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            state     <= state_d;
            is_wr     <= is_wr_d;
            addr_q    <= addr_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            err_cnt   <= err_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= reg_wdata_d;
            reg_we    <= we_d;
            reg_re    <= re_d;
        end
    end

    uart_cmd_txq u_txq (
        .clk        (clk),
        .rst        (rst),
        .load       (q_load),
        .load_cnt   (q_cnt),
        .load_bytes (q_bytes),
        .tx_pop     (tx_pop),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed, table-driven bench for uart_cmd_decoder; honours UART_CMD_WRITE_ACK_EN.
module tb_uart_cmd_decoder;

    localparam int TMO = 40;
`ifdef UART_CMD_WRITE_ACK_EN
    localparam int WR_TX = 1;
`else
    localparam int WR_TX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ack = 1'b0;
    logic        tx_pop = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = 16'h0000;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ack    (rx_ack),
        .tx_pop    (tx_pop),
        .tx_data   (tx_data),
        .tx_ack    (tx_ack),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .err_cnt   (err_cnt)
    );

    // Mid-cycle monitor: counts strobe cycles and records every tx byte
    int         we_cnt = 0;
    int         re_cnt = 0;
    logic [7:0] txs[$];
    always @(negedge clk) begin
        if (reg_we) we_cnt++;
        if (reg_re) re_cnt++;
        if (tx_ack) txs.push_back(tx_data);
    end

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        logic [15:0]     rdata;
        int              we;
        int              re;
        logic [7:0]      addr;
        logic [15:0]     wdata;
        int              err_inc;
        int              ntx;
        logic [0:2][7:0] tx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_ack  = 1'b1;
        @(posedge clk); #1;
        rx_ack  = 1'b0;
    endtask

    task automatic pop_once();
        @(posedge clk); #1;
        tx_pop = 1'b1;
        @(posedge clk); #1;
        tx_pop = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [63:0] bytes, input int n, input logic [15:0] rdata,
                                input int we, input int re, input logic [7:0] addr,
                                input logic [15:0] wdata, input int err_inc, input int ntx,
                                input logic [23:0] tx);
        vec_t v;
        v.b = bytes; v.n = n; v.rdata = rdata; v.we = we; v.re = re; v.addr = addr;
        v.wdata = wdata; v.err_inc = err_inc; v.ntx = ntx; v.tx = tx;
        return v;
    endfunction

    vec_t vecs[6];
    int   exp_err = 0;
    int   we0, re0;

    initial begin
        vecs[0] = mk(64'hA5011012_34370000, 6, 16'h0000, 1, 0, 8'h10, 16'h1234, 0, WR_TX, 24'h5A0000);
        vecs[1] = mk(64'hA5022022_00000000, 4, 16'hBEEF, 0, 1, 8'h20, 16'h1234, 0, 3, 24'h5ABEEF);
        vecs[2] = mk(64'hA5011012_34000000, 6, 16'h0000, 0, 0, 8'h20, 16'h1234, 1, 0, 24'h0);
        vecs[3] = mk(64'hA50155AB_CD320000, 6, 16'h0000, 1, 0, 8'h55, 16'hABCD, 0, WR_TX, 24'h5A0000);
        vecs[4] = mk(64'hA5070000_00000000, 2, 16'h0000, 0, 0, 8'h55, 16'hABCD, 1, 0, 24'h0);
        vecs[5] = mk(64'h0011A502_33310000, 6, 16'h1357, 0, 1, 8'h33, 16'hABCD, 0, 3, 24'h5A1357);

        // Reset state
        cycles(3);
        check("rst_tx_ack", 32'(tx_ack), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check("rst_strobes", 32'({reg_we, reg_re}), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst = 1'b0;
        cycles(2);

        // Pop with an empty queue must never produce tx_ack
        pop_once();
        check("empty_pop_tx", 32'(txs.size()), 32'h0);

        foreach (vecs[k]) begin
            txs.delete();
            we0 = we_cnt;
            re0 = re_cnt;
            reg_rdata = vecs[k].rdata;
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[i]);
            cycles(4);
            for (int i = 0; i < 3; i++) pop_once();
            cycles(2);
            exp_err += vecs[k].err_inc;
            check($sformatf("v%0d_we", k), 32'(we_cnt - we0), 32'(vecs[k].we));
            check($sformatf("v%0d_re", k), 32'(re_cnt - re0), 32'(vecs[k].re));
            check($sformatf("v%0d_addr", k), 32'(reg_addr), 32'(vecs[k].addr));
            check($sformatf("v%0d_wdata", k), 32'(reg_wdata), 32'(vecs[k].wdata));
            check($sformatf("v%0d_err", k), 32'(err_cnt), 32'(exp_err));
            check($sformatf("v%0d_ntx", k), 32'(txs.size()), 32'(vecs[k].ntx));
            for (int i = 0; i < vecs[k].ntx && i < txs.size(); i++)
                check($sformatf("v%0d_tx%0d", k, i), 32'(txs[i]), 32'(vecs[k].tx[i]));
        end

        // Byte arriving while the response is pending is dropped and counted
        txs.delete();
        reg_rdata = 16'hC0DE;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44); send_byte(8'h46);
        cycles(4);
        send_byte(8'hA5);
        exp_err++;
        check("resp_drop_err", 32'(err_cnt), 32'(exp_err));
        for (int i = 0; i < 3; i++) pop_once();
        check("resp_drop_ntx", 32'(txs.size()), 32'h3);
        if (txs.size() == 3) check("resp_drop_lo", 32'(txs[2]), 32'hDE);

        // Timeout mid-packet, then a normal read
        send_byte(8'hA5); send_byte(8'h01);
        cycles(TMO - 10);
        check("tmo_not_early", 32'(err_cnt), 32'(exp_err));
        cycles(20);
        exp_err++;
        check("tmo_err", 32'(err_cnt), 32'(exp_err));
        txs.delete();
        re0 = re_cnt;
        reg_rdata = 16'hBEEF;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
        cycles(4);
        for (int i = 0; i < 3; i++) pop_once();
        check("tmo_after_re", 32'(re_cnt - re0), 32'h1);
        check("tmo_after_ntx", 32'(txs.size()), 32'h3);
        if (txs.size() == 3) check("tmo_after_hi", 32'(txs[1]), 32'hBE);

        // pop held two cycles yields one byte; then reset mid-response
        txs.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
        cycles(4);
        tx_pop = 1'b1;
        cycles(2);
        tx_pop = 1'b0;
        cycles(2);
        check("held_pop_ntx", 32'(txs.size()), 32'h1);
        if (txs.size() == 1) check("held_pop_tx0", 32'(txs[0]), 32'h5A);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("midrst_err", 32'(err_cnt), 32'h0);
        check("midrst_addr", 32'(reg_addr), 32'h0);
        txs.delete();
        for (int i = 0; i < 3; i++) pop_once();
        check("midrst_ntx", 32'(txs.size()), 32'h0);
        we0 = we_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h37);
        cycles(4);
        check("midrst_we", 32'(we_cnt - we0), 32'h1);
        for (int i = 0; i < 3; i++) pop_once();
        check("midrst_wr_ntx", 32'(txs.size()), 32'(WR_TX));

        // err_cnt saturates rather than wrapping
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hA5);
            send_byte(8'h07);
        end
        cycles(2);
        check("err_sat", 32'(err_cnt), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
